way0_inst_cache: RTL

Direct-mapped instruction cache serving the way0 instruction-fetch interface. The fetch unit drives request/instAddr and waits for dataOk/inst. On a hit the cache answers one cycle after acceptance. On a miss it refills a whole line word-by-word from a backing instruction memory over a request/dataOk handshake, then answers.

---
 rtl/way0_inst_cache_if.sv | 31 +++
 rtl/way0_inst_cache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/way0_inst_cache_if.sv
// ---------------------------------------------------------------------------
// way0_inst_cache_if
//   Bundles the two handshakes of the way0 instruction cache:
//     fetch side  : request_i / instAddr_i / flush_i  ->  dataOk_o / inst_o
//     memory side : mem_request_o / mem_addr_o        <-  mem_dataOk_i / mem_data_i
//   Signal suffixes are from the cache's point of view (_i = into the cache).
//   Modports:
//     slave  - the cache itself
//     master - whoever drives fetches and models the backing memory
// ---------------------------------------------------------------------------
interface way0_inst_cache_if;
  logic        request_i;
  logic [31:0] instAddr_i;
  logic        flush_i;
  logic        dataOk_o;
  logic [31:0] inst_o;
  logic        mem_request_o;
  logic [31:0] mem_addr_o;
  logic        mem_dataOk_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  request_i, instAddr_i, flush_i, mem_dataOk_i, mem_data_i,
    output dataOk_o, inst_o, mem_request_o, mem_addr_o
  );

  modport master (
    output request_i, instAddr_i, flush_i, mem_dataOk_i, mem_data_i,
    input  dataOk_o, inst_o, mem_request_o, mem_addr_o
  );
endinterface

// File: rtl/way0_inst_cache.sv
// ---------------------------------------------------------------------------
// way0_inst_cache
//   Direct-mapped instruction cache for the way0 fetch port. A hit answers
//   in the cycle after acceptance; a miss refills the whole line word by word
//   from the backing memory (critical word captured on the way), then answers.
//
//   Parameters:
//     LINES - number of lines (power of 2, >= 2)
//     WORDS - 32-bit words per line (power of 2, >= 2)
//   Ports:
//     clk     - rising-edge clock
//     reset_n - synchronous active-low reset
//     bus     - way0_inst_cache_if.slave (fetch + backing-memory handshakes)
//
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module way0_inst_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input logic              clk,
  input logic              reset_n,
  way0_inst_cache_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESP
  } state_t;

  // ---------------------------------------------------------------------
  // Request address split
  // ---------------------------------------------------------------------
  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic [1:0]       addr_lsb_unused;

  assign addr_off        = bus.instAddr_i[2 +: OFF_W];
  assign addr_idx        = bus.instAddr_i[2 + OFF_W +: IDX_W];
  assign addr_tag        = bus.instAddr_i[31 -: TAG_W];
  // Byte offset within a word plays no part in an instruction fetch.
  assign addr_lsb_unused = bus.instAddr_i[1:0];

  // ---------------------------------------------------------------------
  // Storage: valid bits in resettable flops, tag/data in write-only-when-
  // refilling arrays with an asynchronous read of the indexed line.
  // ---------------------------------------------------------------------
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  logic                   tag_we;
  logic                   data_we;
  logic [IDX_W+OFF_W-1:0] data_waddr;

  logic             lookup_valid;
  logic [TAG_W-1:0] lookup_tag;
  logic [31:0]      lookup_data;

  assign lookup_valid = valid_q[addr_idx];
  assign lookup_tag   = tag_mem[addr_idx];
  assign lookup_data  = data_mem[{addr_idx, addr_off}];

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic [OFF_W-1:0] req_off_q, req_off_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      resp_word_q, resp_word_d;

  // Registered outputs
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_q, inst_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    req_off_d    = req_off_q;
    flush_pend_d = flush_pend_q;
    resp_word_d  = resp_word_q;
    valid_d      = valid_q;
    data_ok_d    = 1'b0;
    inst_d       = inst_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    data_waddr   = {req_idx_q, cnt_q};

    case (state_q)
      S_IDLE: begin
        if (bus.request_i) begin
          // A flush on the accept edge forces a miss even if the
          // pre-clear lookup would have hit.
          if (lookup_valid && (lookup_tag == addr_tag) && !bus.flush_i) begin
            data_ok_d = 1'b1;
            inst_d    = lookup_data;
          end else begin
            state_d    = S_REFILL;
            req_tag_d  = addr_tag;
            req_idx_d  = addr_idx;
            req_off_d  = addr_off;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_tag, addr_idx, {OFF_W{1'b0}}, 2'b00};
          end
        end
        if (bus.flush_i) begin
          valid_d = '0;
        end
      end

      S_REFILL: begin
        if (bus.flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (bus.mem_dataOk_i) begin
          data_we = 1'b1;
          if (cnt_q == req_off_q) begin
            resp_word_d = bus.mem_data_i;
          end
          if (cnt_q != CNT_LAST) begin
            cnt_d      = cnt_q + 1'b1;
            mem_addr_d = mem_addr_q + 32'd4;
          end else begin
            cnt_d              = '0;
            mem_req_d          = 1'b0;
            tag_we             = 1'b1;
            valid_d[req_idx_q] = !flush_pend_q;
            state_d            = S_RESP;
            // The response is registered here so dataOk_o is high during
            // the RESP cycle; the critical word may be arriving right now.
            data_ok_d = 1'b1;
            inst_d    = (cnt_q == req_off_q) ? bus.mem_data_i : resp_word_q;
          end
        end
      end

      S_RESP: begin
        // No acceptance here: the fetch unit sees dataOk_o only now.
        state_d      = S_IDLE;
        flush_pend_d = 1'b0;
        if (flush_pend_q || bus.flush_i) begin
          valid_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_off_q    <= '0;
      flush_pend_q <= 1'b0;
      resp_word_q  <= '0;
      valid_q      <= '0;
      data_ok_q    <= 1'b0;
      inst_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      req_off_q    <= req_off_d;
      flush_pend_q <= flush_pend_d;
      resp_word_q  <= resp_word_d;
      valid_q      <= valid_d;
      data_ok_q    <= data_ok_d;
      inst_q       <= inst_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Array writes; gated by reset so an abandoned refill leaves nothing behind
  // beyond data that the cleared valid bit already hides.
  always_ff @(posedge clk) begin
    if (reset_n && data_we) begin
      data_mem[data_waddr] <= bus.mem_data_i;
    end
    if (reset_n && tag_we) begin
      tag_mem[req_idx_q] <= req_tag_q;
    end
  end

  assign bus.dataOk_o      = data_ok_q;
  assign bus.inst_o        = inst_q;
  assign bus.mem_request_o = mem_req_q;
  assign bus.mem_addr_o    = mem_addr_q;

endmodule
